// File: rtl/fifo4_ctrl.sv
// rtl/fifo4_ctrl.sv - pointer and flag controller turning a 1R/1W register file into a FIFO
module fifo4_ctrl #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] waddr,
  output logic          wren,
  output logic [AW-1:0] raddr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
);

  // Occupancy value that means "every slot holds data"
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;

  // Flags come from the registered count, so they only move on clock edges
  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // A pop needs data present; a push at full rides on a same-cycle pop,
  // writing into the slot the consumer is vacating
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  assign wren  = push_ok;
  assign waddr = wptr;
  assign raddr = rptr;

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointer, occupancy and one-cycle reject pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count <= count_next;
      ovf   <= push & ~push_ok;
      udf   <= pop & empty;
    end
  end

endmodule

// File: tb/tb_fifo4_ctrl.sv
// tb/tb_fifo4_ctrl.sv - table-driven self-checking bench for fifo4_ctrl with a register file model
module tb_fifo4_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] waddr;
  logic       wren;
  logic [1:0] raddr;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int n_cmp = 0;
  int n_bad = 0;

  fifo4_ctrl #(.AW(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .waddr (waddr),
    .wren  (wren),
    .raddr (raddr),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  // Register file the controller drives: synchronous write, combinational read
  logic [7:0] mem [4];
  logic [7:0] dout;
  always @(posedge clk) if (wren) mem[waddr] <= din;
  assign dout = mem[raddr];

  typedef struct {
    logic       flush, push, pop;
    logic [7:0] din;
    logic       exp_wren;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic [2:0] exp_count;
    logic [1:0] exp_waddr, exp_raddr;
    logic       exp_ovf, exp_udf;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic pu, input logic po, input logic [7:0] d,
                              input logic w, input logic cd, input logic [7:0] dv,
                              input logic [2:0] c, input logic [1:0] wa, input logic [1:0] ra,
                              input logic ov, input logic ud);
    vec_t v;
    v.flush = fl; v.push = pu; v.pop = po; v.din = d;
    v.exp_wren = w; v.chk_dout = cd; v.exp_dout = dv;
    v.exp_count = c; v.exp_waddr = wa; v.exp_raddr = ra;
    v.exp_ovf = ov; v.exp_udf = ud;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle: check combinational outputs before the edge, registered ones after
  task automatic step(input vec_t v);
    @(negedge clk);
    flush = v.flush; push = v.push; pop = v.pop; din = v.din;
    #1;
    chk("wren", {31'd0, wren}, {31'd0, v.exp_wren});
    if (v.chk_dout) chk("dout", {24'd0, dout}, {24'd0, v.exp_dout});
    @(posedge clk);
    #1;
    chk("count", {29'd0, count}, {29'd0, v.exp_count});
    chk("full",  {31'd0, full},  {31'd0, (v.exp_count == 3'd4)});
    chk("empty", {31'd0, empty}, {31'd0, (v.exp_count == 3'd0)});
    chk("waddr", {30'd0, waddr}, {30'd0, v.exp_waddr});
    chk("raddr", {30'd0, raddr}, {30'd0, v.exp_raddr});
    chk("ovf",   {31'd0, ovf},   {31'd0, v.exp_ovf});
    chk("udf",   {31'd0, udf},   {31'd0, v.exp_udf});
  endtask

  vec_t vecs [24];

  initial begin
    //           fl pu po din    wr cd dout   cnt wa ra ov ud
    vecs[0]  = mk(0, 1, 0, 8'h0A, 1, 0, 8'h00, 1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 8'h0B, 1, 0, 8'h00, 2, 2, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 8'h0C, 1, 0, 8'h00, 3, 3, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 8'h0D, 1, 0, 8'h00, 4, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 8'hFF, 0, 0, 8'h00, 4, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 4, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 8'h00, 0, 1, 8'h0A, 3, 0, 1, 0, 0);
    vecs[7]  = mk(0, 0, 1, 8'h00, 0, 1, 8'h0B, 2, 0, 2, 0, 0);
    vecs[8]  = mk(0, 0, 1, 8'h00, 0, 1, 8'h0C, 1, 0, 3, 0, 0);
    vecs[9]  = mk(0, 0, 1, 8'h00, 0, 1, 8'h0D, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 8'h0A, 1, 0, 8'h00, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 8'h0B, 1, 0, 8'h00, 2, 2, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 8'h0C, 1, 0, 8'h00, 3, 3, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 8'h0D, 1, 0, 8'h00, 4, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 8'h0E, 1, 1, 8'h0A, 4, 1, 1, 0, 0);
    vecs[15] = mk(0, 0, 1, 8'h00, 0, 1, 8'h0B, 3, 1, 2, 0, 0);
    vecs[16] = mk(0, 0, 1, 8'h00, 0, 1, 8'h0C, 2, 1, 3, 0, 0);
    vecs[17] = mk(0, 0, 1, 8'h00, 0, 1, 8'h0D, 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 8'h00, 0, 1, 8'h0E, 0, 1, 1, 0, 0);
    vecs[19] = mk(0, 1, 1, 8'h05, 1, 0, 8'h00, 1, 2, 1, 0, 1);
    vecs[20] = mk(0, 0, 0, 8'h00, 0, 1, 8'h05, 1, 2, 1, 0, 0);
    vecs[21] = mk(0, 0, 1, 8'h00, 0, 1, 8'h05, 0, 2, 2, 0, 0);
    vecs[22] = mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 2, 2, 0, 1);
    vecs[23] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 2, 0, 0);

    // Power-on reset state
    #12;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_wren",  {31'd0, wren},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) step(vecs[i]);

    // Asynchronous reset mid-stream with three entries queued
    step(mk(0, 1, 0, 8'h31, 1, 0, 8'h00, 1, 3, 2, 0, 0));
    step(mk(0, 1, 0, 8'h32, 1, 0, 8'h00, 2, 0, 2, 0, 0));
    step(mk(0, 1, 0, 8'h33, 1, 0, 8'h00, 3, 1, 2, 0, 0));
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_full",  {31'd0, full},  32'd0);
    chk("arst_waddr", {30'd0, waddr}, 32'd0);
    chk("arst_raddr", {30'd0, raddr}, 32'd0);
    chk("arst_ovf",   {31'd0, ovf},   32'd0);
    chk("arst_udf",   {31'd0, udf},   32'd0);
    chk("arst_wren",  {31'd0, wren},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ten push-then-pop pairs: pointers wrap 3 -> 0 twice, full never set
    for (int i = 0; i < 10; i++) begin
      step(mk(0, 1, 0, 8'(i), 1, 0, 8'h00, 1, 2'((i + 1) % 4), 2'(i % 4), 0, 0));
      step(mk(0, 0, 1, 8'h00, 0, 1, 8'(i), 0, 2'((i + 1) % 4), 2'((i + 1) % 4), 0, 0));
    end

    // Flush with a concurrent push at count 2
    step(mk(0, 1, 0, 8'h11, 1, 0, 8'h00, 1, 3, 2, 0, 0));
    step(mk(0, 1, 0, 8'h22, 1, 0, 8'h00, 2, 0, 2, 0, 0));
    step(mk(1, 1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 8'h44, 1, 0, 8'h00, 1, 1, 0, 0, 0));
    step(mk(0, 0, 0, 8'h00, 0, 1, 8'h44, 1, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
